alu_flag_gen: RTL and testbench

//  Sequential ALU stage directly upstream of the 8-bit flag register.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_mul_iter.sv | 72 +++++++
 rtl/alu_flag_gen.sv | 180 ++++++++++++++++++
 tb/tb_alu_flag_gen.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, flag bit positions and FSM states for alu_flag_gen
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_ADC   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_SBB   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_NOT   = 4'h7;
    localparam logic [3:0] OP_SHL   = 4'h8;
    localparam logic [3:0] OP_SHR   = 4'h9;
    localparam logic [3:0] OP_ROL   = 4'hA;
    localparam logic [3:0] OP_ROR   = 4'hB;
    localparam logic [3:0] OP_INC   = 4'hC;
    localparam logic [3:0] OP_DEC   = 4'hD;
    localparam logic [3:0] OP_MUL   = 4'hE;
    localparam logic [3:0] OP_PASSB = 4'hF;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_S = 2;
    localparam int FLG_V = 3;
    localparam int FLG_P = 4;
    localparam int FLG_H = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - W-cycle shift-add multiplier; done_o pulses when product_o is final
module alu_mul_iter #(
    parameter int W = 8
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] product_o
);

    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (start_i && !busy_q) begin
            // The start edge already performs iteration 0 from the raw operands.
            acc_d    = b_i[0] ? {{W{1'b0}}, a_i} : '0;
            mcand_d  = {{(W-1){1'b0}}, a_i, 1'b0};
            mplier_d = b_i >> 1;
            cnt_d    = CW'(W - 1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign done_o    = done_q;
    assign product_o = acc_q;

endmodule

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - ALU stage producing Result and {2'b00,H,P,V,S,Z,C}; ALU_MUL_EN adds iterative MUL
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [3:0]   Op,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
    output logic         Busy,
    output logic         Done,
    output logic [W-1:0] Result,
    output logic [7:0]   Flags
);

    function automatic logic [7:0] mk_flags(input logic [W-1:0] r, input logic c,
                                            input logic v, input logic h);
        logic [7:0] f;
        f        = '0;
        f[FLG_C] = c;
        f[FLG_Z] = (r == '0);
        f[FLG_S] = r[W-1];
        f[FLG_V] = v;
        f[FLG_P] = ~^r;
        f[FLG_H] = h;
        return f;
    endfunction

    logic [W-1:0] result_q, result_d;
    logic [7:0]   flags_q, flags_d;
    logic         done_q, done_d;

    logic [W-1:0] alu_res;
    logic [7:0]   alu_flags;
    logic [W-1:0] ar_b;
    logic         ar_ci, ar_sub, ar_c, ar_v, ar_h, illegal;
    logic [W:0]   ar_wide;
    logic [4:0]   ar_nib;

    always_comb begin
        ar_b    = B;
        ar_ci   = 1'b0;
        ar_sub  = (Op == OP_SUB) || (Op == OP_SBB) || (Op == OP_DEC);
        illegal = 1'b0;
        if (Op == OP_ADC || Op == OP_SBB) ar_ci = Cin;
        if (Op == OP_INC || Op == OP_DEC) ar_b  = W'(1);

        if (ar_sub) begin
            ar_wide = {1'b0, A} - {1'b0, ar_b} - {{W{1'b0}}, ar_ci};
            ar_nib  = {1'b0, A[3:0]} - {1'b0, ar_b[3:0]} - {4'b0, ar_ci};
            ar_v    = (A[W-1] != ar_b[W-1]) && (ar_wide[W-1] != A[W-1]);
        end else begin
            ar_wide = {1'b0, A} + {1'b0, ar_b} + {{W{1'b0}}, ar_ci};
            ar_nib  = {1'b0, A[3:0]} + {1'b0, ar_b[3:0]} + {4'b0, ar_ci};
            ar_v    = (A[W-1] == ar_b[W-1]) && (ar_wide[W-1] != A[W-1]);
        end
        ar_h = ar_nib[4];
        ar_c = ar_wide[W];

        alu_res = '0;
        case (Op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB: alu_res = ar_wide[W-1:0];
            OP_INC, OP_DEC: begin
                alu_res = ar_wide[W-1:0];
                ar_c    = Cin;
            end
            OP_AND:   alu_res = A & B;
            OP_OR:    alu_res = A | B;
            OP_XOR:   alu_res = A ^ B;
            OP_NOT:   alu_res = ~A;
            OP_SHL: begin alu_res = {A[W-2:0], 1'b0};   ar_c = A[W-1]; end
            OP_SHR: begin alu_res = {1'b0, A[W-1:1]};   ar_c = A[0];   end
            OP_ROL: begin alu_res = {A[W-2:0], A[W-1]}; ar_c = A[W-1]; end
            OP_ROR: begin alu_res = {A[0], A[W-1:1]};   ar_c = A[0];   end
            OP_PASSB: alu_res = B;
            default:  illegal = 1'b1;
        endcase

        case (Op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_INC, OP_DEC:
                alu_flags = mk_flags(alu_res, ar_c, ar_v, ar_h);
            OP_SHL, OP_SHR, OP_ROL, OP_ROR:
                alu_flags = mk_flags(alu_res, ar_c, 1'b0, 1'b0);
            default:
                alu_flags = mk_flags(alu_res, 1'b0, 1'b0, 1'b0);
        endcase
        // An unbuilt or unknown opcode reports all-zero flags, not Z.
        if (illegal) alu_flags = '0;
    end

`ifdef ALU_MUL_EN
    state_e         state_q, state_d;
    logic           mul_start, mul_done, mul_hi_nz;
    logic [2*W-1:0] mul_prod;

    alu_mul_iter #(.W(W)) u_mul (
        .clk_i     (Clk),
        .reset_i   (Reset),
        .start_i   (mul_start),
        .a_i       (A),
        .b_i       (B),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    assign mul_hi_nz = |mul_prod[2*W-1:W];

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (Op == OP_MUL) begin
                        state_d   = ST_MUL;
                        mul_start = 1'b1;
                    end else begin
                        result_d = alu_res;
                        flags_d  = alu_flags;
                        done_d   = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    result_d = mul_prod[W-1:0];
                    flags_d  = mk_flags(mul_prod[W-1:0], mul_hi_nz, mul_hi_nz, 1'b0);
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    assign Busy = (state_q == ST_MUL);
`else
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        if (Start) begin
            result_d = alu_res;
            flags_d  = alu_flags;
            done_d   = 1'b1;
        end
    end

    assign Busy = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    assign Done   = done_q;
    assign Result = result_q;
    assign Flags  = flags_q;

endmodule

// File: tb/tb_alu_flag_gen.sv
// tb/tb_alu_flag_gen.sv - directed self-checking bench for alu_flag_gen (MUL steps under ALU_MUL_EN)
module tb_alu_flag_gen;

    logic       Clk = 1'b0;
    logic       Reset, Start, Cin, Busy, Done;
    logic [3:0] Op;
    logic [7:0] A, B, Result, Flags;

    int n_vec = 0;
    int n_err = 0;

    alu_flag_gen #(.W(8)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .Op     (Op),
        .A      (A),
        .B      (B),
        .Cin    (Cin),
        .Busy   (Busy),
        .Done   (Done),
        .Result (Result),
        .Flags  (Flags)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the Start edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic cin);
        Op = op; A = a; B = b; Cin = cin; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic expect_done(input string tag, input logic [7:0] res, input logic [7:0] flg);
        check({tag, ".done"},   {31'b0, Done},   32'd1);
        check({tag, ".result"}, {24'b0, Result}, {24'b0, res});
        check({tag, ".flags"},  {24'b0, Flags},  {24'b0, flg});
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Op = 4'h0; A = '0; B = '0; Cin = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        check("rst.result", {24'b0, Result}, 32'h00);
        check("rst.flags",  {24'b0, Flags},  32'h00);
        check("rst.busy",   {31'b0, Busy},   32'd0);
        check("rst.done",   {31'b0, Done},   32'd0);

        issue(4'h0, 8'h7F, 8'h01, 1'b0);
        expect_done("add7f", 8'h80, 8'h2C);
        @(negedge Clk);
        check("add7f.pulse", {31'b0, Done}, 32'd0);
        check("add7f.hold",  {24'b0, Result}, 32'h80);

        // 0xFF has eight ones: even parity sets P.
        issue(4'h2, 8'h00, 8'h01, 1'b0);
        expect_done("sub", 8'hFF, 8'h35);

        issue(4'h9, 8'h01, 8'h00, 1'b0);
        expect_done("shr", 8'h00, 8'h13);
        issue(4'h8, 8'h81, 8'h00, 1'b0);
        expect_done("shl_b2b", 8'h02, 8'h01);

        issue(4'h1, 8'h0F, 8'h00, 1'b1);
        expect_done("adc", 8'h10, 8'h20);
        issue(4'h3, 8'h10, 8'h0F, 1'b1);
        expect_done("sbb", 8'h00, 8'h32);
        issue(4'hC, 8'hFF, 8'h00, 1'b1);
        expect_done("inc", 8'h00, 8'h33);
        issue(4'hD, 8'h80, 8'h00, 1'b0);
        expect_done("dec", 8'h7F, 8'h28);
        issue(4'hB, 8'h01, 8'h00, 1'b0);
        expect_done("ror", 8'h80, 8'h05);
        issue(4'hA, 8'h80, 8'h00, 1'b0);
        expect_done("rol", 8'h01, 8'h01);
        issue(4'h7, 8'h0F, 8'h00, 1'b0);
        expect_done("not", 8'hF0, 8'h14);
        issue(4'h6, 8'hAA, 8'h55, 1'b0);
        expect_done("xor", 8'hFF, 8'h14);
        issue(4'h4, 8'hAA, 8'h55, 1'b0);
        expect_done("and", 8'h00, 8'h12);
        issue(4'h5, 8'h81, 8'h02, 1'b0);
        expect_done("or", 8'h83, 8'h04);
        issue(4'hF, 8'hEE, 8'h03, 1'b0);
        expect_done("passb", 8'h03, 8'h10);
        issue(4'h0, 8'hFF, 8'h01, 1'b0);
        expect_done("add_wrap", 8'h00, 8'h33);

`ifdef ALU_MUL_EN
        issue(4'hE, 8'h10, 8'h10, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("mul.busy%0d", i), {31'b0, Busy}, 32'd1);
            check($sformatf("mul.done%0d", i), {31'b0, Done}, 32'd0);
            if (i == 3) begin
                issue(4'h0, 8'h02, 8'h03, 1'b0);
            end else begin
                @(negedge Clk);
            end
        end
        check("mul.busy_end", {31'b0, Busy}, 32'd0);
        expect_done("mul", 8'h00, 8'h1B);
        @(negedge Clk);
        check("mul.ignored_start", {31'b0, Done}, 32'd0);

        issue(4'hE, 8'h10, 8'h10, 1'b0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("mulrst.busy",   {31'b0, Busy},   32'd0);
        check("mulrst.result", {24'b0, Result}, 32'h00);
        check("mulrst.flags",  {24'b0, Flags},  32'h00);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("mulrst.nodone%0d", i), {31'b0, Done}, 32'd0);
            @(negedge Clk);
        end
`else
        issue(4'hE, 8'h10, 8'h10, 1'b0);
        check("mul_illegal.busy", {31'b0, Busy}, 32'd0);
        expect_done("mul_illegal", 8'h00, 8'h00);

        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("rst2.result", {24'b0, Result}, 32'h00);
        check("rst2.flags",  {24'b0, Flags},  32'h00);
        check("rst2.done",   {31'b0, Done},   32'd0);
`endif

        issue(4'h0, 8'h02, 8'h03, 1'b0);
        expect_done("add23", 8'h05, 8'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
